// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Constants shared by the pipeline control logic. Holds the
//                RV32 major opcodes the decode and hazard logic switch on,
//                and the state encoding of the hazard sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Major opcodes, instruction bits [6:0]
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BCC   = 7'b1100011;
    localparam logic [6:0] LCC   = 7'b0000011;
    localparam logic [6:0] SCC   = 7'b0100011;
    localparam logic [6:0] MCC   = 7'b0010011;
    localparam logic [6:0] RCC   = 7'b0110011;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [6:0] CUS   = 7'b0001011;

    // Hazard sequencer state encoding
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] CUS_WAIT = 2'd2;
    localparam logic [1:0] HALTED   = 2'd3;

    typedef enum logic [1:0] {
        S_RUN      = RUN,
        S_FLUSH    = FLUSH,
        S_CUS_WAIT = CUS_WAIT,
        S_HALTED   = HALTED
    } hz_state_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Purely combinational load-use hazard detect. Decodes which
//                source registers the decode-stage instruction actually reads
//                and compares them against the destination of a load in EX.
//  Ports       : i_inst        - instruction in decode
//                i_ex_rd       - destination register of the EX instruction
//                i_ex_is_load  - EX instruction is a load
//                o_hazard      - load-use hazard present
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_is_load,
    output logic        o_hazard
);

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_unused_fields;

    assign w_opcode = i_inst[6:0];
    assign w_rs1    = i_inst[19:15];
    assign w_rs2    = i_inst[24:20];

    // U-type and JAL carry immediate bits in the rs1 field
    assign w_rs1_used = (w_opcode != LUI) && (w_opcode != AUIPC) && (w_opcode != JAL);
    // Only branches, stores and register-register ALU ops read rs2
    assign w_rs2_used = (w_opcode == BCC) || (w_opcode == SCC) || (w_opcode == RCC);

    assign o_hazard = i_ex_is_load && (i_ex_rd != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == i_ex_rd)) ||
                       (w_rs2_used && (w_rs2 == i_ex_rd)));

    // Fields not involved in the operand-usage decode
    assign w_unused_fields = ^{i_inst[31:25], i_inst[14:7]};

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central stall/flush sequencer of the 5-stage pipeline.
//                Resolves load-use hazards, taken-branch flush windows,
//                multi-cycle custom operations and debug halt/resume.
//                Optional macro PIPE_PERF_CNT_EN enables a saturating count
//                of HLT cycles on o_stall_cycles; otherwise it reads 0.
//  Ports       : i_clk / i_rst_n    - clock, async active-low reset
//                i_if_id_inst       - instruction in decode
//                i_id_ex_rd         - destination of EX instruction
//                i_id_ex_is_load    - EX instruction is a load
//                i_branch_taken     - branch resolved taken (pulse)
//                i_cus_start/done   - custom op issue / completion (pulses)
//                i_dbg_halt_req     - debug halt request (level)
//                i_dbg_resume       - debug resume (pulse)
//                o_hlt              - freeze PC, IF/ID, ID/EX
//                o_if_id_flush      - load NOP into IF/ID
//                o_id_ex_bubble     - load NOP into ID/EX
//                o_dbg_halt_ack     - pipeline halted
//                o_cus_err          - custom-op timeout pulse
//                o_stall_cycles     - count of HLT cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import ctrl_pkg::*;
#(
    parameter int FLUSH_CYC   = 2,
    parameter int CUS_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_if_id_inst,
    input  logic [4:0]       i_id_ex_rd,
    input  logic             i_id_ex_is_load,
    input  logic             i_branch_taken,
    input  logic             i_cus_start,
    input  logic             i_cus_done,
    input  logic             i_dbg_halt_req,
    input  logic             i_dbg_resume,
    output logic             o_hlt,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_dbg_halt_ack,
    output logic             o_cus_err,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam logic [3:0] c_flush_reload = 4'(FLUSH_CYC - 1);
    localparam logic [9:0] c_tout_last    = 10'(CUS_TIMEOUT - 1);

    hz_state_t  r_state;
    hz_state_t  w_state_nxt;
    logic [3:0] r_flush_cnt;
    logic [3:0] w_flush_cnt_nxt;
    logic [9:0] r_tout_cnt;
    logic [9:0] w_tout_cnt_nxt;

    logic w_load_use;
    logic w_hlt;
    logic w_flush;
    logic w_bubble;
    logic w_ack;
    logic w_err;

    load_use_detect u_load_use_detect (
        .i_inst       (i_if_id_inst),
        .i_ex_rd      (i_id_ex_rd),
        .i_ex_is_load (i_id_ex_is_load),
        .o_hazard     (w_load_use)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 4'd0;
            r_tout_cnt  <= 10'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_tout_cnt  <= w_tout_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_tout_cnt_nxt  = r_tout_cnt;
        w_hlt           = 1'b0;
        w_flush         = 1'b0;
        w_bubble        = 1'b0;
        w_ack           = 1'b0;
        w_err           = 1'b0;

        case (r_state)
            S_RUN: begin
                if (i_branch_taken) begin
                    // Branch cycle is the first flush cycle; a one-cycle
                    // window needs no FLUSH state at all.
                    w_flush         = 1'b1;
                    w_bubble        = 1'b1;
                    w_flush_cnt_nxt = c_flush_reload;
                    w_state_nxt     = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
                end else if (i_cus_start) begin
                    w_tout_cnt_nxt  = 10'd0;
                    w_state_nxt     = S_CUS_WAIT;
                end else if (w_load_use) begin
                    w_hlt           = 1'b1;
                    w_bubble        = 1'b1;
                end else if (i_dbg_halt_req) begin
                    w_state_nxt     = S_HALTED;
                end
            end

            S_FLUSH: begin
                if (i_branch_taken) begin
                    w_flush         = 1'b1;
                    w_bubble        = 1'b1;
                    w_flush_cnt_nxt = c_flush_reload;
                    w_state_nxt     = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
                end else begin
                    if (r_flush_cnt != 4'd0) begin
                        w_flush         = 1'b1;
                        w_bubble        = 1'b1;
                        w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                    end
                    // Leave as the counter reaches zero so no idle FLUSH
                    // cycle is spent with load-use detection disabled.
                    if (r_flush_cnt <= 4'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end

            S_CUS_WAIT: begin
                w_hlt = 1'b1;
                if (i_cus_done) begin
                    w_state_nxt = S_RUN;
                end else if (r_tout_cnt == c_tout_last) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_tout_cnt_nxt = r_tout_cnt + 10'd1;
                end
            end

            S_HALTED: begin
                w_hlt = 1'b1;
                w_ack = 1'b1;
                if (i_dbg_resume) begin
                    w_state_nxt = S_RUN;
                end
            end

            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Input-driven RUN terms would otherwise leak through while reset is held
    assign o_hlt          = i_rst_n & w_hlt;
    assign o_if_id_flush  = i_rst_n & w_flush;
    assign o_id_ex_bubble = i_rst_n & w_bubble;
    assign o_dbg_halt_ack = i_rst_n & w_ack;
    assign o_cus_err      = i_rst_n & w_err;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hlt && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cycles = r_stall_cnt;
`else
    assign o_stall_cycles = '0;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl. A table of
//                load-use vectors plus directed sequences for branch flush,
//                custom-op wait/timeout, debug halt, async reset and the
//                stall counter (second instance with CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    import ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        br;
    logic        cs;
    logic        cd;
    logic        hreq;
    logic        resume;

    logic        hlt, flush, bubble, ack, err;
    logic [31:0] stall;
    logic        hlt4, flush4, bubble4, ack4, err4;
    logic [3:0]  stall4;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_hazard_ctrl #(.FLUSH_CYC(2), .CUS_TIMEOUT(64), .CNT_W(32)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_id_inst(inst), .i_id_ex_rd(ex_rd),
        .i_id_ex_is_load(ex_is_load), .i_branch_taken(br), .i_cus_start(cs),
        .i_cus_done(cd), .i_dbg_halt_req(hreq), .i_dbg_resume(resume),
        .o_hlt(hlt), .o_if_id_flush(flush), .o_id_ex_bubble(bubble),
        .o_dbg_halt_ack(ack), .o_cus_err(err), .o_stall_cycles(stall)
    );

    pipe_hazard_ctrl #(.FLUSH_CYC(2), .CUS_TIMEOUT(64), .CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_id_inst(inst), .i_id_ex_rd(ex_rd),
        .i_id_ex_is_load(ex_is_load), .i_branch_taken(br), .i_cus_start(cs),
        .i_cus_done(cd), .i_dbg_halt_req(hreq), .i_dbg_resume(resume),
        .o_hlt(hlt4), .o_if_id_flush(flush4), .o_id_ex_bubble(bubble4),
        .o_dbg_halt_ack(ack4), .o_cus_err(err4), .o_stall_cycles(stall4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        is_load;
        logic        exp_stall;
    } lu_vec_t;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst = 32'h0000_0013; ex_rd = 5'd0; ex_is_load = 1'b0;
        br = 1'b0; cs = 1'b0; cd = 1'b0; hreq = 1'b0; resume = 1'b0;
    endtask

    lu_vec_t vec[16];

    initial begin
        // Table: {name, inst, EX rd, EX is_load, expected stall}
        vec[0]  = '{"add_rs1",     mk(RCC,   5'd6, 5'd5, 5'd7), 5'd5, 1'b1, 1'b1};
        vec[1]  = '{"add_rd_x0",   mk(RCC,   5'd6, 5'd0, 5'd7), 5'd0, 1'b1, 1'b0};
        vec[2]  = '{"add_rs2",     mk(RCC,   5'd6, 5'd7, 5'd5), 5'd5, 1'b1, 1'b1};
        vec[3]  = '{"add_noload",  mk(RCC,   5'd6, 5'd5, 5'd7), 5'd5, 1'b0, 1'b0};
        vec[4]  = '{"addi_imm",    mk(MCC,   5'd6, 5'd7, 5'd5), 5'd5, 1'b1, 1'b0};
        vec[5]  = '{"addi_rs1",    mk(MCC,   5'd6, 5'd5, 5'd1), 5'd5, 1'b1, 1'b1};
        vec[6]  = '{"sw_rs2",      mk(SCC,   5'd0, 5'd7, 5'd5), 5'd5, 1'b1, 1'b1};
        vec[7]  = '{"beq_rs2",     mk(BCC,   5'd0, 5'd7, 5'd5), 5'd5, 1'b1, 1'b1};
        vec[8]  = '{"lui",         mk(LUI,   5'd6, 5'd5, 5'd5), 5'd5, 1'b1, 1'b0};
        vec[9]  = '{"auipc",       mk(AUIPC, 5'd6, 5'd5, 5'd5), 5'd5, 1'b1, 1'b0};
        vec[10] = '{"jal",         mk(JAL,   5'd6, 5'd5, 5'd5), 5'd5, 1'b1, 1'b0};
        vec[11] = '{"jalr_rs1",    mk(JALR,  5'd6, 5'd5, 5'd7), 5'd5, 1'b1, 1'b1};
        vec[12] = '{"jalr_rs2f",   mk(JALR,  5'd6, 5'd7, 5'd5), 5'd5, 1'b1, 1'b0};
        vec[13] = '{"cus_rs1",     mk(CUS,   5'd6, 5'd5, 5'd7), 5'd5, 1'b1, 1'b1};
        vec[14] = '{"cus_rs2f",    mk(CUS,   5'd6, 5'd7, 5'd5), 5'd5, 1'b1, 1'b0};
        vec[15] = '{"lw_rs1",      mk(LCC,   5'd6, 5'd5, 5'd0), 5'd5, 1'b1, 1'b1};

        // ---------------- reset ----------------
        idle();
        rst_n = 1'b0;
        #3;
        chk("rst_hlt", 32'(hlt), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_bubble", 32'(bubble), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", stall, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // ---------------- load-use table ----------------
        for (int i = 0; i < 16; i++) begin
            tick();
            inst = vec[i].inst; ex_rd = vec[i].rd; ex_is_load = vec[i].is_load;
            #1;
            chk({"lu_hlt_", vec[i].name}, 32'(hlt), 32'(vec[i].exp_stall));
            chk({"lu_bubble_", vec[i].name}, 32'(bubble), 32'(vec[i].exp_stall));
            chk({"lu_flush_", vec[i].name}, 32'(flush), 32'd0);
            tick();
            ex_is_load = 1'b0;
            #1;
            chk({"lu_clear_", vec[i].name}, 32'(hlt), 32'd0);
        end
        idle();

        // ---------------- branch flush, load-use suppressed ----------------
        tick();
        br = 1'b1; inst = mk(RCC, 5'd6, 5'd5, 5'd7); ex_rd = 5'd5; ex_is_load = 1'b1;
        #1;
        chk("br_flush_c1", 32'(flush), 32'd1);
        chk("br_bubble_c1", 32'(bubble), 32'd1);
        chk("br_lu_suppressed", 32'(hlt), 32'd0);
        tick(); idle(); #1;
        chk("br_flush_c2", 32'(flush), 32'd1);
        chk("br_bubble_c2", 32'(bubble), 32'd1);
        tick(); #1;
        chk("br_flush_end", 32'(flush), 32'd0);
        chk("br_bubble_end", 32'(bubble), 32'd0);

        // ---------------- double branch extends window ----------------
        tick(); br = 1'b1; #1;
        chk("br2_c1", 32'(flush), 32'd1);
        tick(); br = 1'b1; #1;
        chk("br2_c2", 32'(flush), 32'd1);
        tick(); br = 1'b0; #1;
        chk("br2_c3", 32'(flush), 32'd1);
        tick(); #1;
        chk("br2_end", 32'(flush), 32'd0);

        // ---------------- custom op, done after 5 cycles ----------------
        tick(); cs = 1'b1; #1;
        chk("cus_issue_hlt", 32'(hlt), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick(); cs = 1'b0; cd = (i == 5); #1;
            chk("cus_wait_hlt", 32'(hlt), 32'd1);
            chk("cus_wait_err", 32'(err), 32'd0);
        end
        tick(); cd = 1'b0; #1;
        chk("cus_done_hlt", 32'(hlt), 32'd0);

        // ---------------- custom op timeout ----------------
        tick(); cs = 1'b1; #1;
        for (int i = 1; i <= 64; i++) begin
            tick(); cs = 1'b0; #1;
            chk("tout_hlt", 32'(hlt), 32'd1);
            chk("tout_err", 32'(err), 32'(i == 64));
        end
        tick(); #1;
        chk("tout_after_hlt", 32'(hlt), 32'd0);
        chk("tout_after_err", 32'(err), 32'd0);

        // ---------------- done and timeout in the same cycle ----------------
        tick(); cs = 1'b1; #1;
        for (int i = 1; i <= 64; i++) begin
            tick(); cs = 1'b0; cd = (i == 64); #1;
            chk("tie_err", 32'(err), 32'd0);
        end
        tick(); cd = 1'b0; #1;
        chk("tie_after_hlt", 32'(hlt), 32'd0);
        chk("tie_after_err", 32'(err), 32'd0);

        // ---------------- halt request together with branch ----------------
        tick(); hreq = 1'b1; br = 1'b1; #1;
        chk("hb_flush_c1", 32'(flush), 32'd1);
        chk("hb_ack_c1", 32'(ack), 32'd0);
        tick(); br = 1'b0; #1;
        chk("hb_flush_c2", 32'(flush), 32'd1);
        chk("hb_ack_c2", 32'(ack), 32'd0);
        tick(); #1;
        chk("hb_run_flush", 32'(flush), 32'd0);
        chk("hb_run_ack", 32'(ack), 32'd0);
        tick(); #1;
        chk("hb_halt_ack", 32'(ack), 32'd1);
        chk("hb_halt_hlt", 32'(hlt), 32'd1);
        tick(); resume = 1'b1; #1;
        chk("hb_resume_ack", 32'(ack), 32'd1);
        tick(); resume = 1'b0; #1;
        chk("hb_fwd_hlt", 32'(hlt), 32'd0);
        chk("hb_fwd_ack", 32'(ack), 32'd0);
        tick(); #1;
        chk("hb_rehalt_ack", 32'(ack), 32'd1);
        chk("hb_rehalt_hlt", 32'(hlt), 32'd1);
        hreq = 1'b0;
        tick(); resume = 1'b1; #1;
        chk("hb_res2_ack", 32'(ack), 32'd1);
        tick(); resume = 1'b0; #1;
        chk("hb_released_ack", 32'(ack), 32'd0);
        chk("hb_released_hlt", 32'(hlt), 32'd0);
        tick(); resume = 1'b1; #1;
        chk("resume_in_run_hlt", 32'(hlt), 32'd0);
        tick(); resume = 1'b0; #1;
        chk("resume_in_run_ack", 32'(ack), 32'd0);

        // ---------------- async reset mid custom wait ----------------
        tick(); cs = 1'b1; #1;
        tick(); cs = 1'b0; #1;
        chk("ar_wait_hlt", 32'(hlt), 32'd1);
        #2 rst_n = 1'b0; cd = 1'b1;
        #1;
        chk("ar_hlt", 32'(hlt), 32'd0);
        chk("ar_ack", 32'(ack), 32'd0);
        chk("ar_err", 32'(err), 32'd0);
        chk("ar_flush", 32'(flush), 32'd0);
        chk("ar_bubble", 32'(bubble), 32'd0);
        chk("ar_stall", stall, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ar_release_hlt", 32'(hlt), 32'd0);
        tick(); cd = 1'b0; #1;
        chk("ar_run_hlt", 32'(hlt), 32'd0);
        inst = mk(RCC, 5'd6, 5'd5, 5'd7); ex_rd = 5'd5; ex_is_load = 1'b1; #1;
        chk("ar_run_loaduse", 32'(hlt), 32'd1);
        idle();

        // ---------------- stall counter ----------------
        tick();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        hreq = 1'b1;
        repeat (21) tick();
        chk("perf_ack4", 32'(ack4), 32'd1);
`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall32", stall, 32'd20);
        chk("perf_stall4_sat", 32'(stall4), 32'd15);
`else
        chk("perf_stall32", stall, 32'd0);
        chk("perf_stall4", 32'(stall4), 32'd0);
`endif
        hreq = 1'b0; resume = 1'b1;
        tick(); resume = 1'b0; #1;
        chk("perf_release_hlt", 32'(hlt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
